// File: rtl/score_scale_rowmax_norm.sv
// score_scale_rowmax_norm: scale 4x4 FP32 scores, subtract row max, stream out.
// Define SCORE_SCALE_EN to multiply each score by SCALE before the max search.

`ifdef SCORE_SCALE_EN
module multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  logic [31:0] a, b, z;
  logic        have_a, have_b;
  logic [47:0] p;
  logic [23:0] m;
  logic [24:0] mr;
  logic [9:0]  e;
  logic        g, s, sign;
  logic        unused_bits;

  assign input_a_ack = ~have_a & ~output_z_stb;
  assign input_b_ack = ~have_b & ~output_z_stb;
  assign unused_bits = ^{mr[23], e[8]};

  // Normal operands only; subnormals and underflow flush to signed zero.
  always_comb begin
    sign = a[31] ^ b[31];
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    if (p[47]) begin
      m = p[47:24];
      g = p[23];
      s = |p[22:0];
      e = e + 10'd1;
    end else begin
      m = p[46:23];
      g = p[22];
      s = |p[21:0];
    end
    mr = {1'b0, m} + {24'd0, g & (s | m[0])};
    if (mr[24]) begin
      mr = mr >> 1;
      e = e + 10'd1;
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e[9] || e == 10'd0)
      z = {sign, 31'd0};
    else
      z = {sign, e[7:0], mr[22:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      have_a <= 1'b0;
      have_b <= 1'b0;
      output_z <= '0;
      output_z_stb <= 1'b0;
    end else begin
      if (input_a_stb && input_a_ack) begin
        a <= input_a;
        have_a <= 1'b1;
      end
      if (input_b_stb && input_b_ack) begin
        b <= input_b;
        have_b <= 1'b1;
      end
      if (have_a && have_b) begin
        output_z <= z;
        output_z_stb <= 1'b1;
        have_a <= 1'b0;
        have_b <= 1'b0;
      end else if (output_z_stb && output_z_ack) begin
        output_z_stb <= 1'b0;
      end
    end
  end
endmodule
`endif

module adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);
  logic [31:0] a, b, z;
  logic        have_a, have_b;
  logic [7:0]  ea, eb, ed;
  logic [26:0] xa, xb, big, sml, sh;
  logic [27:0] sum;
  logic [24:0] mr;
  logic [9:0]  e;
  logic [4:0]  lz;
  logic        swap, sign, lost, nz, g, s;
  logic        unused_bits;

  assign input_a_ack = ~have_a & ~output_z_stb;
  assign input_b_ack = ~have_b & ~output_z_stb;
  assign unused_bits = ^{mr[23], e[8]};

  // Guard/round/sticky alignment, then RNE; exact zero is +0 unless both -0.
  always_comb begin
    ea = a[30:23];
    eb = b[30:23];
    xa = (ea == 8'd0) ? 27'd0 : {1'b1, a[22:0], 3'b000};
    xb = (eb == 8'd0) ? 27'd0 : {1'b1, b[22:0], 3'b000};
    swap = {eb, xb} > {ea, xa};
    big = swap ? xb : xa;
    sml = swap ? xa : xb;
    ed = swap ? eb - ea : ea - eb;
    e = {2'b00, swap ? eb : ea};
    sign = swap ? b[31] : a[31];
    sh = (ed > 8'd26) ? 27'd0 : (sml >> ed);
    lost = (ed > 8'd26) ? |sml : |(sml & ((27'd1 << ed) - 27'd1));
    sh[0] = sh[0] | lost;
    if (a[31] == b[31])
      sum = {1'b0, big} + {1'b0, sh};
    else
      sum = {1'b0, big} - {1'b0, sh};
    nz = |sum;
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e = e + 10'd1;
    end
    lz = '0;
    for (int k = 0; k < 27; k++)
      if (sum[k]) lz = 5'(26 - k);
    sum = sum << lz;
    e = e - {5'd0, lz};
    g = sum[2];
    s = sum[1] | sum[0];
    mr = {1'b0, sum[26:3]} + {24'd0, g & (s | sum[3])};
    if (mr[24]) begin
      mr = mr >> 1;
      e = e + 10'd1;
    end
    if (!nz || e[9] || e == 10'd0)
      z = {a[31] & b[31], 31'd0};
    else
      z = {sign, e[7:0], mr[22:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      have_a <= 1'b0;
      have_b <= 1'b0;
      output_z <= '0;
      output_z_stb <= 1'b0;
    end else begin
      if (input_a_stb && input_a_ack) begin
        a <= input_a;
        have_a <= 1'b1;
      end
      if (input_b_stb && input_b_ack) begin
        b <= input_b;
        have_b <= 1'b1;
      end
      if (have_a && have_b) begin
        output_z <= z;
        output_z_stb <= 1'b1;
        have_a <= 1'b0;
        have_b <= 1'b0;
      end else if (output_z_stb && output_z_ack) begin
        output_z_stb <= 1'b0;
      end
    end
  end
endmodule

module score_scale_rowmax_norm #(
  parameter logic [31:0] SCALE = 32'h3DB504F3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [3:0]   score_rd_addr,
  output logic         score_rd_en,
  input  logic [31:0]  score_rd_data,
  output logic [31:0]  out_data,
  output logic [3:0]   out_idx,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] rowmax_flat,
  output logic         busy,
  output logic         done
);
  typedef enum logic [3:0] {
    IDLE, RD, RD_WAIT, CAP, MUL_GO, MUL_WAIT,
    UPD, SUB_GO, SUB_WAIT, EMIT
  } state_t;

  state_t      state, state_nx;
  logic [1:0]  i, j;
  logic        start_d, start_p, fp_rst;
  logic [31:0] raw, scl, rmax;
  logic [31:0] scaled [4];
  logic        add_a_stb, add_b_stb;
  logic        add_a_ack, add_b_ack;
  logic        add_z_stb;
  logic [31:0] add_z;

  assign start_p = start & ~start_d;
  assign score_rd_en = (state == RD);
  assign score_rd_addr = {i, j};
  assign rmax = rowmax_flat[32*i +: 32];

  function automatic logic fp_gt(input logic [31:0] x, input logic [31:0] y);
    logic r;
    if (x[30:0] == 31'd0 && y[30:0] == 31'd0)
      r = 1'b0;
    else if (x[31] != y[31])
      r = ~x[31];
    else if (!x[31])
      r = x[30:0] > y[30:0];
    else
      r = x[30:0] < y[30:0];
    return r;
  endfunction

`ifdef SCORE_SCALE_EN
  logic        mul_a_stb, mul_b_stb;
  logic        mul_a_ack, mul_b_ack;
  logic        mul_z_stb;
  logic [31:0] mul_z, prod;

  assign scl = prod;

  multiplier u_mul (
    .clk          (clk),
    .rst          (fp_rst),
    .input_a      (raw),
    .input_a_stb  (mul_a_stb),
    .input_a_ack  (mul_a_ack),
    .input_b      (SCALE),
    .input_b_stb  (mul_b_stb),
    .input_b_ack  (mul_b_ack),
    .output_z     (mul_z),
    .output_z_stb (mul_z_stb),
    .output_z_ack (1'b1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_stb <= 1'b0;
      mul_b_stb <= 1'b0;
      prod <= '0;
    end else begin
      if (state == MUL_GO) begin
        mul_a_stb <= 1'b1;
        mul_b_stb <= 1'b1;
      end else begin
        if (mul_a_stb && mul_a_ack) mul_a_stb <= 1'b0;
        if (mul_b_stb && mul_b_ack) mul_b_stb <= 1'b0;
      end
      if (state == MUL_WAIT && mul_z_stb) prod <= mul_z;
    end
  end
`else
  logic unused_scale;

  assign scl = raw;
  assign unused_scale = ^SCALE;
`endif

  // Subtract via addition of the sign-flipped row max.
  adder u_add (
    .clk          (clk),
    .rst          (fp_rst),
    .input_a      (scaled[j]),
    .input_a_stb  (add_a_stb),
    .input_a_ack  (add_a_ack),
    .input_b      ({~rmax[31], rmax[30:0]}),
    .input_b_stb  (add_b_stb),
    .input_b_ack  (add_b_ack),
    .output_z     (add_z),
    .output_z_stb (add_z_stb),
    .output_z_ack (1'b1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fp_rst <= 1'b1;
    else      fp_rst <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start_p) state_nx = RD;
      RD:       state_nx = RD_WAIT;
      RD_WAIT:  state_nx = CAP;
`ifdef SCORE_SCALE_EN
      CAP:      state_nx = MUL_GO;
      MUL_GO:   state_nx = MUL_WAIT;
      MUL_WAIT: if (mul_z_stb) state_nx = UPD;
`else
      CAP:      state_nx = UPD;
`endif
      UPD:      state_nx = (j == 2'd3) ? SUB_GO : RD;
      SUB_GO:   state_nx = SUB_WAIT;
      SUB_WAIT: if (add_z_stb) state_nx = EMIT;
      EMIT: begin
        if (out_ready) begin
          if (j != 2'd3)      state_nx = SUB_GO;
          else if (i != 2'd3) state_nx = RD;
          else                state_nx = IDLE;
        end
      end
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_d <= 1'b0;
      i <= '0;
      j <= '0;
      raw <= '0;
      for (int k = 0; k < 4; k++) scaled[k] <= '0;
      rowmax_flat <= '0;
      out_data <= '0;
      out_idx <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      add_a_stb <= 1'b0;
      add_b_stb <= 1'b0;
    end else begin
      start_d <= start;
      done <= 1'b0;
      if (add_a_stb && add_a_ack) add_a_stb <= 1'b0;
      if (add_b_stb && add_b_ack) add_b_stb <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_p) begin
            busy <= 1'b1;
            i <= '0;
            j <= '0;
          end
        end
        CAP: raw <= score_rd_data;
        UPD: begin
          scaled[j] <= scl;
          if (j == 2'd0 || fp_gt(scl, rmax))
            rowmax_flat[32*i +: 32] <= scl;
          j <= j + 2'd1;
        end
        SUB_GO: begin
          add_a_stb <= 1'b1;
          add_b_stb <= 1'b1;
        end
        SUB_WAIT: begin
          if (add_z_stb) begin
            out_data <= add_z;
            out_idx <= {i, j};
            out_valid <= 1'b1;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            j <= j + 2'd1;
            if (j == 2'd3) begin
              i <= i + 2'd1;
              if (i == 2'd3) begin
                done <= 1'b1;
                busy <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
